// File: rtl/psum_out_drain_if.sv
// Row-in / word-out bus of the psum drain, plus its status outputs.
// The master is the core/host side; the slave is the drain itself.
interface psum_out_drain_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int out_bw  = 32,
    parameter int depth   = 4
);
    logic                      in_valid;
    logic [psum_bw*col-1:0]    in_data;
    logic                      out_valid;
    logic [out_bw-1:0]         out_data;
    logic                      out_last;
    logic                      out_ready;
    logic [$clog2(depth):0]    level;
    logic                      overflow;
    logic [15:0]               rows_out;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, level, overflow, rows_out
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, level, overflow, rows_out
    );
endinterface

// File: rtl/psum_out_drain.sv
// Buffers SFP result rows from the core and serializes them into out_bw words
// over valid/ready; rows arriving while the buffer is full are dropped and flagged.
module psum_out_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int out_bw  = 32,
    parameter int depth   = 4
) (
    input  logic clk,
    input  logic reset,
    psum_out_drain_if.slave bus
);
    localparam int WPR = psum_bw * col / out_bw;
    localparam int AW  = $clog2(depth);
    localparam int CW  = AW + 1;
    localparam int IW  = (WPR > 1) ? $clog2(WPR) : 1;

    typedef logic [WPR-1:0][out_bw-1:0] row_t;

    row_t            mem_q [depth];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     rows_out_q, rows_out_d;

    logic out_valid, xfer, last, pop, push, drop;
    row_t rd_row;

    assign out_valid = (count_q != '0);
    assign last      = (idx_q == IW'(WPR - 1));
    assign xfer      = out_valid && bus.out_ready;
    assign pop       = xfer && last;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign push      = bus.in_valid && ((count_q != CW'(depth)) || pop);
    assign drop      = bus.in_valid && !push;
    assign rd_row    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | drop;
        rows_out_d = rows_out_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (xfer) begin
            if (last) begin
                idx_d      = '0;
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rows_out_d = rows_out_q + 16'd1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            rows_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            rows_out_q <= rows_out_d;
        end
    end

    // Row storage carries no reset; stale contents are never presented.
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = rd_row[idx_q];
    assign bus.out_last  = out_valid && last;
    assign bus.level     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.rows_out  = rows_out_q;
endmodule

// File: tb/tb_psum_out_drain.sv
// Directed bench for psum_out_drain: expected words are queued when rows are issued
// and a separate monitor compares every accepted word and checks stall stability.
module tb_psum_out_drain;
    logic clk = 1'b0;
    logic reset;

    psum_out_drain_if #(.col(8), .psum_bw(16), .out_bw(32), .depth(4)) bus ();

    psum_out_drain #(.col(8), .psum_bw(16), .out_bw(32), .depth(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] mkrow(input logic [15:0] base);
        logic [127:0] r;
        for (int c = 0; c < 8; c++) r[c*16 +: 16] = base + 16'(c);
        return r;
    endfunction

    task automatic expect_row(input logic [15:0] base);
        exp_t e;
        for (int w = 0; w < 4; w++) begin
            e.data = {base + 16'(2*w + 1), base + 16'(2*w)};
            e.last = (w == 3);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: inputs change #1 after posedge, so the negedge sees what the next edge samples.
    initial begin
        exp_t        e;
        logic        stall;
        logic [31:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                    check("stall_data", bus.out_data, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected none", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", bus.out_data, e.data);
                        check("word_last", {31'd0, bus.out_last}, {31'd0, e.last});
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                held  = bus.out_data;
            end
        end
    end

    initial begin
        exp_t e;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_level", {29'd0, bus.level}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_rows_out", {16'd0, bus.rows_out}, 32'd0);

        // Single row, hand-computed words
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mkrow(16'h0000);
        e = '{32'h0001_0000, 1'b0}; exp_q.push_back(e);
        e = '{32'h0003_0002, 1'b0}; exp_q.push_back(e);
        e = '{32'h0005_0004, 1'b0}; exp_q.push_back(e);
        e = '{32'h0007_0006, 1'b1}; exp_q.push_back(e);
        step(1);
        bus.in_valid = 1'b0;
        check("t1_latency_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_first_word", bus.out_data, 32'h0001_0000);
        check("t1_level", {29'd0, bus.level}, 32'd1);
        step(4);
        check("t1_rows_out", {16'd0, bus.rows_out}, 32'd1);
        check("t1_level_end", {29'd0, bus.level}, 32'd0);
        check("t1_valid_end", {31'd0, bus.out_valid}, 32'd0);

        // Back-pressure for 5 cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = mkrow(16'h0010);
        expect_row(16'h0010);
        step(1);
        bus.in_valid = 1'b0;
        step(5);
        check("t2_hold_data", bus.out_data, 32'h0011_0010);
        check("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        step(4);
        check("t2_rows_out", {16'd0, bus.rows_out}, 32'd2);
        check("t2_level", {29'd0, bus.level}, 32'd0);

        // Fill to depth, fifth row dropped
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mkrow(16'h0020 + 16'(k * 16));
            if (k < 4) expect_row(16'h0020 + 16'(k * 16));
            step(1);
        end
        bus.in_valid = 1'b0;
        check("t3_level_full", {29'd0, bus.level}, 32'd4);
        check("t3_overflow", {31'd0, bus.overflow}, 32'd1);
        bus.out_ready = 1'b1;
        step(16);
        check("t3_rows_out", {16'd0, bus.rows_out}, 32'd6);
        check("t3_overflow_sticky", {31'd0, bus.overflow}, 32'd1);
        check("t3_level_end", {29'd0, bus.level}, 32'd0);

        // Full buffer with push and pop on the same edge
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        step(1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mkrow(16'h0070 + 16'(k * 16));
            expect_row(16'h0070 + 16'(k * 16));
            step(1);
        end
        bus.in_valid = 1'b0;
        check("t4_level_full", {29'd0, bus.level}, 32'd4);
        bus.out_ready = 1'b1;
        step(3);
        bus.in_valid = 1'b1;
        bus.in_data  = mkrow(16'h00B0);
        expect_row(16'h00B0);
        step(1);
        bus.in_valid = 1'b0;
        check("t4_level_stays", {29'd0, bus.level}, 32'd4);
        check("t4_no_overflow", {31'd0, bus.overflow}, 32'd0);
        step(16);
        check("t4_rows_out", {16'd0, bus.rows_out}, 32'd5);

        // Back-to-back rows every 4 cycles, no bubble
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mkrow(16'h00C0 + 16'(k * 16));
            expect_row(16'h00C0 + 16'(k * 16));
            step(1);
            bus.in_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (j > 0) step(1);
                check("t5_valid", {31'd0, bus.out_valid}, 32'd1);
                check("t5_level", {29'd0, bus.level}, 32'd1);
            end
        end
        step(1);
        check("t5_rows_out", {16'd0, bus.rows_out}, 32'd9);
        check("t5_level_end", {29'd0, bus.level}, 32'd0);

        // Reset mid-row with 3 rows buffered
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mkrow(16'h00D0 + 16'(k * 16));
            expect_row(16'h00D0 + 16'(k * 16));
            step(1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step(2);
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        step(1);
        reset = 1'b0;
        exp_q.delete();
        check("t6_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t6_level", {29'd0, bus.level}, 32'd0);
        check("t6_rows_out", {16'd0, bus.rows_out}, 32'd0);
        check("t6_overflow", {31'd0, bus.overflow}, 32'd0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mkrow(16'h0100);
        expect_row(16'h0100);
        step(1);
        bus.in_valid = 1'b0;
        check("t6_word0", bus.out_data, 32'h0101_0100);
        step(4);
        check("t6_rows_out_end", {16'd0, bus.rows_out}, 32'd1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
        check("drain_complete", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
